// File: rtl/c1351_pot.sv
// c1351_pot: PS/2 mouse packets to rate-limited SID POTX/POTY readings (1351 emulation).
// Optional joystick mode is enabled by defining C1351_JOYMODE_EN.
module c1351_pot #(
    parameter int SHIFT     = 0,
    parameter int MAX_STEP  = 31,
    parameter int PEND_BITS = 12,
    parameter int JOY_HOLD  = 20000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [24:0] ps2_mouse,
    input  logic        pot_sample,
    output logic [7:0]  potX,
    output logic [7:0]  potY,
    output logic [1:0]  button,
    output logic [4:0]  joy,
    output logic        joy_mode
);
    localparam int PW = 6 + SHIFT;
    localparam int W  = PEND_BITS + 2;
    localparam logic signed [W-1:0] LIM = {3'b000, {(PEND_BITS-1){1'b1}}};
    localparam logic signed [W-1:0] MS  = W'(MAX_STEP);
    localparam logic signed [W-1:0] Z   = '0;

    logic                        t24, armed, ev;
    logic [16:0]                 lfsr;
    logic signed [PEND_BITS-1:0] pend_x, pend_y;
    logic [PW-1:0]               pos_x, pos_y;
    logic signed [W-1:0]         dx, dy, step_x, step_y, nxt_x, nxt_y;
    logic                        unused_bits;

    function automatic logic signed [W-1:0] clamp(input logic signed [W-1:0] v, input logic signed [W-1:0] lim);
        return v > lim ? lim : v < -lim ? -lim : v;
    endfunction

    assign ev = armed && (ps2_mouse[24] != t24);
    assign dx = $signed({{(W-9){ps2_mouse[4]}}, ps2_mouse[4], ps2_mouse[15:8]});
    assign dy = $signed({{(W-9){ps2_mouse[5]}}, ps2_mouse[5], ps2_mouse[23:16]});
    assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:2], nxt_x[W-1:PEND_BITS], nxt_y[W-1:PEND_BITS]};

    // step comes from the old pend, so a coinciding packet adds on top of the drained value
    always_comb begin
        step_x = clamp(W'(pend_x), MS);
        step_y = clamp(W'(pend_y), MS);
        nxt_x  = clamp(W'(pend_x) - (pot_sample ? step_x : Z) + (ev ? dx : Z), LIM);
        nxt_y  = clamp(W'(pend_y) - (pot_sample ? step_y : Z) + (ev ? dy : Z), LIM);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            t24    <= 1'b0;
            armed  <= 1'b0;
            lfsr   <= 17'h00001;
            button <= 2'b00;
            pend_x <= '0;
            pend_y <= '0;
            pos_x  <= '0;
            pos_y  <= '0;
        end else begin
            t24    <= ps2_mouse[24];
            armed  <= 1'b1;
            lfsr   <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
            button <= ps2_mouse[1:0];
            if (!joy_mode) begin
                pend_x <= nxt_x[PEND_BITS-1:0];
                pend_y <= nxt_y[PEND_BITS-1:0];
                if (pot_sample) begin
                    pos_x <= pos_x + step_x[PW-1:0];
                    pos_y <= pos_y + step_y[PW-1:0];
                end
            end
        end
    end

    assign potX = joy_mode ? 8'hFF : {1'b0, pos_x[5+SHIFT:SHIFT], lfsr[0]};
    assign potY = joy_mode ? 8'hFF : {1'b0, pos_y[5+SHIFT:SHIFT], lfsr[8]};

`ifdef C1351_JOYMODE_EN
    localparam int CW = $clog2(JOY_HOLD + 1);
    localparam logic [CW-1:0] HOLD = CW'(JOY_HOLD);

    logic          got;
    logic [CW-1:0] cu, cd, cl, cr;

    // a load on one direction cancels its opposite so joy never shows both
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            got      <= 1'b0;
            joy_mode <= 1'b0;
            cu       <= '0;
            cd       <= '0;
            cl       <= '0;
            cr       <= '0;
        end else begin
            if (ev && !got) begin
                got      <= 1'b1;
                joy_mode <= ps2_mouse[1];
            end
            cr <= ev && dx > Z ? HOLD : ev && dx < Z ? '0 : cr != 0 ? cr - 1'b1 : cr;
            cl <= ev && dx < Z ? HOLD : ev && dx > Z ? '0 : cl != 0 ? cl - 1'b1 : cl;
            cu <= ev && dy > Z ? HOLD : ev && dy < Z ? '0 : cu != 0 ? cu - 1'b1 : cu;
            cd <= ev && dy < Z ? HOLD : ev && dy > Z ? '0 : cd != 0 ? cd - 1'b1 : cd;
        end
    end

    assign joy = joy_mode ? {button[0], cr != 0, cl != 0, cd != 0, (cu != 0) | button[1]} : 5'b0;
`else
    logic unused_joy;
    assign unused_joy = JOY_HOLD > 0;
    assign joy_mode   = 1'b0;
    assign joy        = 5'b0;
`endif
endmodule

// File: tb/tb_c1351_pot.sv
// tb_c1351_pot: table-driven scoreboard bench for c1351_pot (SHIFT=0 and SHIFT=2 instances).
module tb_c1351_pot;
    logic        clk = 0, reset = 1;
    logic [24:0] ps2 = 25'h1000000, ps2_b = '0;
    logic        ps = 0, ps_b = 0;
    logic [7:0]  px, py, pxb, pyb;
    logic [1:0]  btn, btnb;
    logic [4:0]  joy, joyb;
    logic        jm, jmb;
    logic        tog = 1;
    logic [16:0] lf;
    int          passed = 0, total = 0;

    typedef struct {logic [5:0] x, y; logic [1:0] b;} exp_t;
    typedef struct {logic pkt; logic [8:0] dx, dy; logic [1:0] b; logic sim; int n; logic [5:0] ex, ey;} vec_t;
    exp_t sb[$];
    vec_t v[12];

    c1351_pot dut (.clk_sys(clk), .reset(reset), .ps2_mouse(ps2), .pot_sample(ps),
                   .potX(px), .potY(py), .button(btn), .joy(joy), .joy_mode(jm));
    c1351_pot #(.SHIFT(2)) dut_b (.clk_sys(clk), .reset(reset), .ps2_mouse(ps2_b), .pot_sample(ps_b),
                   .potX(pxb), .potY(pyb), .button(btnb), .joy(joyb), .joy_mode(jmb));

    always #5 clk = ~clk;

    // noise reference: 17-bit LFSR, bit0^bit3 fed in at the MSB
    always @(posedge clk or posedge reset) lf <= reset ? 17'h00001 : {lf[0] ^ lf[3], lf[16:1]};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", name, got, exp);
    endtask

    task tick;
        @(posedge clk);
        #1;
    endtask

    task automatic packet(input logic [8:0] dx, input logic [8:0] dy, input logic [1:0] b, input logic sim);
        tog = ~tog;
        ps2 = {tog, dy[7:0], dx[7:0], 2'b00, dy[8], dx[8], 2'b00, b};
        ps = sim;
        tick;
        ps = 0;
    endtask

    task automatic strobe(input int n);
        repeat (n) begin
            ps = 1;
            tick;
            ps = 0;
        end
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, " empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        check({name, " potX"}, px[6:1], e.x);
        check({name, " potY"}, py[6:1], e.y);
        check({name, " msb"}, {px[7], py[7]}, 0);
        check({name, " noise"}, {px[0], py[0]}, {lf[0], lf[8]});
        check({name, " button"}, btn, e.b);
    endtask

    initial begin
        v[0]  = '{1, 9'h19C, 9'h000, 2'b00, 0, 1, 6'd33, 6'd0};
        v[1]  = '{0, 9'h000, 9'h000, 2'b00, 0, 1, 6'd2,  6'd0};
        v[2]  = '{0, 9'h000, 9'h000, 2'b00, 0, 1, 6'd35, 6'd0};
        v[3]  = '{0, 9'h000, 9'h000, 2'b00, 0, 1, 6'd28, 6'd0};
        v[4]  = '{0, 9'h000, 9'h000, 2'b00, 0, 1, 6'd28, 6'd0};
        v[5]  = '{1, 9'h000, 9'h028, 2'b00, 0, 0, 6'd28, 6'd0};
        v[6]  = '{1, 9'h000, 9'h005, 2'b00, 1, 0, 6'd28, 6'd31};
        v[7]  = '{0, 9'h000, 9'h000, 2'b00, 0, 1, 6'd28, 6'd45};
        v[8]  = '{0, 9'h000, 9'h000, 2'b00, 0, 1, 6'd28, 6'd45};
        v[9]  = '{1, 9'h000, 9'h1CE, 2'b00, 0, 2, 6'd28, 6'd59};
        v[10] = '{1, 9'h00A, 9'h1FF, 2'b01, 0, 1, 6'd38, 6'd58};
        v[11] = '{0, 9'h000, 9'h000, 2'b11, 0, 0, 6'd38, 6'd58};

        #12;
        check("reset potX", px, 8'h01);
        check("reset potY", py, 8'h00);
        check("reset button", btn, 0);
        check("reset joy", {jm, joy}, 0);
        @(posedge clk);
        #1 reset = 0;
        tick;
        strobe(10);
        check("idle potX", px[7:1], 0);
        check("idle potY", py[7:1], 0);

        packet(9'h00A, 9'h000, 2'b00, 0);
        sb.push_back('{6'd10, 6'd0, 2'b00});
        strobe(1);
        pop_check("single");
        sb.push_back('{6'd10, 6'd0, 2'b00});
        strobe(1);
        pop_check("drained");

        #2 reset = 1;
        tog = ~tog;
        ps2 = {tog, 8'h00, 8'h0A, 8'h00};
        #1;
        check("async potX", px, 8'h01);
        check("async potY", py, 8'h00);
        @(posedge clk);
        #1 reset = 0;
        tick;
        sb.push_back('{6'd0, 6'd0, 2'b00});
        strobe(1);
        pop_check("first toggle");

        foreach (v[i]) begin
            sb.push_back('{v[i].ex, v[i].ey, v[i].b});
            if (v[i].pkt) packet(v[i].dx, v[i].dy, v[i].b, v[i].sim);
            else begin
                ps2[1:0] = v[i].b;
                tick;
            end
            strobe(v[i].n);
            pop_check($sformatf("vec%0d", i));
        end

        repeat (9) packet(9'h0FF, 9'h000, 2'b00, 0);
        sb.push_back('{6'd5, 6'd58, 2'b00});
        strobe(1);
        pop_check("sat first");
        sb.push_back('{6'd37, 6'd58, 2'b00});
        strobe(69);
        pop_check("sat final");

        ps2_b = {1'b1, 8'h00, 8'h08, 8'h00};
        tick;
        ps_b = 1;
        tick;
        ps_b = 0;
        check("shift2 potX", pxb[7:1], 2);
        ps2_b = {1'b0, 8'h00, 8'h03, 8'h00};
        tick;
        ps_b = 1;
        tick;
        ps_b = 0;
        check("shift2 pos11", pxb[7:1], 2);
        ps2_b = {1'b1, 8'h00, 8'h01, 8'h00};
        tick;
        ps_b = 1;
        tick;
        ps_b = 0;
        check("shift2 pos12", pxb[7:1], 3);
        check("shift2 potY", pyb[7:1], 0);

`ifdef C1351_JOYMODE_EN
        begin
            int n;
            reset = 1;
            tick;
            reset = 0;
            tick;
            packet(9'h001, 9'h000, 2'b10, 0);
            check("joy latch", jm, 1);
            strobe(1);
            check("joy potX", px, 8'hFF);
            check("joy potY", py, 8'hFF);
            packet(9'h1FD, 9'h000, 2'b10, 0);
            check("joy left", joy[2], 1);
            check("joy right", joy[3], 0);
            n = 0;
            while (joy[2] && n < 30000) begin
                n++;
                tick;
            end
            check("joy hold", n, 20000);
        end
`else
        packet(9'h001, 9'h000, 2'b10, 0);
        check("no joy_mode", jm, 0);
        check("no joy", joy, 0);
        strobe(1);
        check("mouse potX", px[7:1], 38);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
